// File: rtl/hilo_mdu_if.sv
// Handshake and HI/LO write bundle between the pipeline and the multiply/divide sequencer.
// master = pipeline side (drives requests), slave = hilo_mdu_ctrl.
interface hilo_mdu_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] regaData_i;
    logic [31:0] regbData_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic        dz_o;
    logic [31:0] wLoData;
    logic [31:0] wHiData;
    logic        wlo;
    logic        whi;

    modport master (
        output start_i, op_i, regaData_i, regbData_i, flush_i,
        input  stall_o, busy_o, done_o, dz_o, wLoData, wHiData, wlo, whi
    );

    modport slave (
        input  start_i, op_i, regaData_i, regbData_i, flush_i,
        output stall_o, busy_o, done_o, dz_o, wLoData, wHiData, wlo, whi
    );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply/divide sequencer: latency-timed multiply, 32-step restoring divide.
// Optional macro MDU_DIV_EARLY_EN: finish divides with |A|<|B| in one cycle.
module hilo_mdu_ctrl #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    hilo_mdu_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic        uns_q;
    logic        sa_q;
    logic        sb_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;
    logic        wlo_q;
    logic        whi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;

    logic        sa_in;
    logic        sb_in;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] rem_sh;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    // Request decode: sign flags only for the signed ops (0 and 2), divide magnitudes.
    always_comb begin
        sa_in = ~bus.op_i[0] & bus.regaData_i[31];
        sb_in = ~bus.op_i[0] & bus.regbData_i[31];
        if (sa_in) begin
            a_abs = 32'd0 - bus.regaData_i;
        end else begin
            a_abs = bus.regaData_i;
        end
        if (sb_in) begin
            b_abs = 32'd0 - bus.regbData_i;
        end else begin
            b_abs = bus.regbData_i;
        end
    end

    // One restoring divide step plus the sign fix-up applied on the last step.
    always_comb begin
        rem_sh = {rem_q, quo_q[31]};
        if (rem_sh >= {1'b0, b_q}) begin
            rem_step = rem_sh[31:0] - b_q;
            quo_step = {quo_q[30:0], 1'b1};
        end else begin
            rem_step = rem_sh[31:0];
            quo_step = {quo_q[30:0], 1'b0};
        end
        if (sa_q ^ sb_q) begin
            quo_fix = 32'd0 - quo_step;
        end else begin
            quo_fix = quo_step;
        end
        if (sa_q) begin
            rem_fix = 32'd0 - rem_step;
        end else begin
            rem_fix = rem_step;
        end
    end

    // Sign- or zero-extended operands make a truncated 64-bit product correct for both ops.
    always_comb begin
        if (uns_q) begin
            ext_a = {32'd0, a_q};
            ext_b = {32'd0, b_q};
        end else begin
            ext_a = {{32{a_q[31]}}, a_q};
            ext_b = {{32{b_q[31]}}, b_q};
        end
        prod = ext_a * ext_b;
    end

    // Sequencer FSM with registered completion strobe and write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            uns_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            wlo_q   <= 1'b0;
            whi_q   <= 1'b0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            wlo_q  <= 1'b0;
            whi_q  <= 1'b0;
            lo_q   <= 32'd0;
            hi_q   <= 32'd0;
            if (bus.flush_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            uns_q <= bus.op_i[0];
                            sa_q  <= sa_in;
                            sb_q  <= sb_in;
                            a_q   <= bus.regaData_i;
                            if (!bus.op_i[1]) begin
                                b_q     <= bus.regbData_i;
                                cnt_q   <= 5'(MUL_CYCLES - 1);
                                state_q <= S_MUL;
                                busy_q  <= 1'b1;
                            end else if (bus.regbData_i == 32'd0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                dz_q    <= 1'b1;
                                lo_q    <= 32'hFFFF_FFFF;
                                hi_q    <= bus.regaData_i;
`ifdef MDU_DIV_EARLY_EN
                            end else if (a_abs < b_abs) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                wlo_q   <= 1'b1;
                                whi_q   <= 1'b1;
                                lo_q    <= 32'd0;
                                hi_q    <= bus.regaData_i;
`endif
                            end else begin
                                b_q     <= b_abs;
                                rem_q   <= 32'd0;
                                quo_q   <= a_abs;
                                cnt_q   <= 5'd31;
                                state_q <= S_DIV;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    S_MUL: begin
                        if (cnt_q == 5'd0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            wlo_q   <= 1'b1;
                            whi_q   <= 1'b1;
                            lo_q    <= prod[31:0];
                            hi_q    <= prod[63:32];
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    S_DIV: begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        if (cnt_q == 5'd0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            wlo_q   <= 1'b1;
                            whi_q   <= 1'b1;
                            lo_q    <= quo_fix;
                            hi_q    <= rem_fix;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.stall_o = busy_q | ((state_q == S_IDLE) & bus.start_i);
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.dz_o    = dz_q;
    assign bus.wLoData = lo_q;
    assign bus.wHiData = hi_q;
    assign bus.wlo     = wlo_q;
    assign bus.whi     = whi_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Self-checking bench for hilo_mdu_ctrl: timeline/arithmetic model plus directed literal vectors.
module tb_hilo_mdu_ctrl;

    localparam int MC = 4;
`ifdef MDU_DIV_EARLY_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hilo_mdu_if bus();

    hilo_mdu_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Model of the operation in flight: issue cycle, completion cycle, flush cycle, result.
    bit          m_active  = 1'b0;
    int          m_T       = 0;
    int          m_done_at = 0;
    int          m_flush   = 32'h7fff_ffff;
    logic [31:0] m_lo      = 32'd0;
    logic [31:0] m_hi      = 32'd0;
    logic        m_dz      = 1'b0;

    // Values captured from the DUT at each completion pulse.
    int          cap_n   = 0;
    int          cap_cyc = 0;
    logic [31:0] cap_lo  = 32'd0;
    logic [31:0] cap_hi  = 32'd0;
    logic        cap_dz  = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Result and latency straight from the arithmetic definition of each op.
    function automatic void model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                         output logic [31:0] lo, output logic [31:0] hi,
                                         output logic dz, output int lat);
        longint      sa_l;
        longint      sb_l;
        longint      q;
        longint      r;
        longint      ma;
        longint      mb;
        logic [63:0] p;
        sa_l = longint'($signed(a));
        sb_l = longint'($signed(b));
        dz   = 1'b0;
        if (op == 2'd0 || op == 2'd1) begin
            if (op == 2'd0) p = 64'(sa_l * sb_l);
            else            p = {32'd0, a} * {32'd0, b};
            lo  = p[31:0];
            hi  = p[63:32];
            lat = MC + 1;
        end else if (b == 32'd0) begin
            dz  = 1'b1;
            lo  = 32'hFFFF_FFFF;
            hi  = a;
            lat = 1;
        end else begin
            if (op == 2'd3) begin
                sa_l = longint'(a);
                sb_l = longint'(b);
            end
            q  = sa_l / sb_l;
            r  = sa_l % sb_l;
            lo = q[31:0];
            hi = r[31:0];
            ma = (sa_l < 0) ? -sa_l : sa_l;
            mb = (sb_l < 0) ? -sb_l : sb_l;
            lat = (ma < mb) ? EARLY_LAT : 33;
        end
    endfunction

    bit          e_in_op;
    bit          e_busy;
    bit          e_done;
    bit          e_idle;
    bit          e_stall;

    // Per-cycle comparison of every output against the model timeline.
    always @(negedge clk) begin
        e_in_op = m_active && (cyc > m_T) && (cyc <= m_flush);
        e_busy  = e_in_op && (cyc < m_done_at);
        e_done  = m_active && (cyc == m_done_at) && (m_flush >= m_done_at);
        e_idle  = !(e_in_op && (cyc <= m_done_at));
        e_stall = e_busy || (e_idle && bus.start_i);
        check("busy_o",  64'(bus.busy_o),  64'(e_busy));
        check("stall_o", 64'(bus.stall_o), 64'(e_stall));
        check("done_o",  64'(bus.done_o),  64'(e_done));
        check("dz_o",    64'(bus.dz_o),    64'(e_done && m_dz));
        check("wlo",     64'(bus.wlo),     64'(e_done && !m_dz));
        check("whi",     64'(bus.whi),     64'(e_done && !m_dz));
        check("wLoData", 64'(bus.wLoData), e_done ? 64'(m_lo) : 64'd0);
        check("wHiData", 64'(bus.wHiData), e_done ? 64'(m_hi) : 64'd0);
        if (bus.done_o) begin
            cap_n++;
            cap_cyc = cyc;
            cap_lo  = bus.wLoData;
            cap_hi  = bus.wHiData;
            cap_dz  = bus.dz_o;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Issue one op in the current cycle; hold keeps start_i high (with scrambled operands) that many extra cycles.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        int lat;
        model_result(op, a, b, m_lo, m_hi, m_dz, lat);
        m_active  = 1'b1;
        m_T       = cyc;
        m_done_at = cyc + lat;
        m_flush   = 32'h7fff_ffff;
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.regaData_i = a;
        bus.regbData_i = b;
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            bus.regaData_i = ~a;
            bus.regbData_i = b + 32'd3;
            @(posedge clk); #1;
        end
        bus.start_i = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit_lo, input logic [31:0] lit_hi,
                          input logic lit_dz, input int lit_lat, input int hold, input string nm);
        int n0;
        int t0;
        n0 = cap_n;
        t0 = cyc;
        issue(op, a, b, hold);
        for (int i = 0; i < 60 && cap_n == n0; i++) begin
            @(posedge clk); #1;
        end
        check({nm, " completion seen"}, 64'(cap_n), 64'(n0 + 1));
        check({nm, " latency"}, 64'(cap_cyc - t0), 64'(lit_lat));
        check({nm, " LO"}, 64'(cap_lo), 64'(lit_lo));
        check({nm, " HI"}, 64'(cap_hi), 64'(lit_hi));
        check({nm, " dz"}, 64'(cap_dz), 64'(lit_dz));
    endtask

    initial begin
        int t0;
        int n0;
        bus.start_i    = 1'b0;
        bus.op_i       = 2'd0;
        bus.regaData_i = 32'd0;
        bus.regbData_i = 32'd0;
        bus.flush_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",  64'(bus.busy_o),  64'd0);
        check("reset done",  64'(bus.done_o),  64'd0);
        check("reset wlo",   64'(bus.wlo),     64'd0);
        check("reset LO",    64'(bus.wLoData), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, MC + 1, 2, "MULT -1*2");
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MC + 1, 0, "MULTU");
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0, MC + 1, 0, "MULT min*min");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0, "DIV -7/2");
        run_op(3'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0, "DIVU 100/7");
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 0, "DIV 7/-2");
        run_op(2'd2, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33, 0, "DIV min/1");
        run_op(2'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0, "DIVU 5/0");
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 0, "DIV -5/0");
        run_op(2'd3, 32'd3, 32'd9, 32'd0, 32'd3, 1'b0, EARLY_LAT, 0, "DIVU 3/9");
        run_op(2'd2, 32'hFFFF_FFFD, 32'd9, 32'd0, 32'hFFFF_FFFD, 1'b0, EARLY_LAT, 0, "DIV -3/9");

        // Flush ten cycles into a divide: back to IDLE, no completion.
        n0 = cap_n;
        t0 = cyc;
        issue(2'd2, 32'd100, 32'd3, 0);
        for (int i = 0; i < 20 && cyc < t0 + 10; i++) begin
            @(posedge clk); #1;
        end
        bus.flush_i = 1'b1;
        m_flush     = cyc;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        check("flush busy low", 64'(bus.busy_o), 64'd0);
        check("flush cycle", 64'(cyc - t0), 64'd11);
        repeat (30) @(posedge clk);
        #1;
        check("flush no write", 64'(cap_n), 64'(n0));

        // Reset mid-divide clears outputs asynchronously.
        n0 = cap_n;
        issue(2'd2, 32'd100, 32'd3, 0);
        repeat (5) @(posedge clk);
        #2;
        rst      = 1'b1;
        m_active = 1'b0;
        #1;
        check("rst busy",  64'(bus.busy_o),  64'd0);
        check("rst stall", 64'(bus.stall_o), 64'd0);
        check("rst done",  64'(bus.done_o),  64'd0);
        check("rst whi",   64'(bus.whi),     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        check("rst no write", 64'(cap_n), 64'(n0));

        run_op(2'd1, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, MC + 1, 0, "MULTU after reset");
        run_op(2'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0, "DIVU back-to-back");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
